// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings, default width
// and the majority helper used by the full-adder slice.
package serial_add_unit_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Carry-out of a full adder is the majority of its three inputs.
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/dff.sv
// One-bit carry flip-flop cell: synchronous reset, parallel load of cy_in,
// otherwise captures in. Reset dominates load.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic cy_in,
    input  logic in,
    output logic out
);

    // Carry storage with reset > load > data priority.
    always_ff @(posedge clk) begin
        if (rst)       out <= 1'b0;
        else if (load) out <= cy_in;
        else           out <= in;
    end

endmodule

// File: rtl/serial_add_unit_fa.sv
// One-bit full-adder slice, purely combinational.
module fa_bit
    import serial_add_unit_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj(a, b, cin);

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder: operands are loaded into right-shift registers and one
// bit pair per cycle (LSB first) goes through a full-adder slice. The carry
// lives in the dff cell between bits; sum bits shift in from the top.
module serial_add_unit
    import serial_add_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    count;
    logic             carry;
    logic             s_bit;
    logic             maj_bit;
    logic             start_accept;
    logic             carry_load;
    logic             carry_rst;
    logic             carry_d;

    // A new operation may start from IDLE or straight out of DONE.
    assign start_accept = start & ((state == IDLE) | (state == DONE));

    fa_bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (maj_bit)
    );

    // Carry flop drive: cleared while idle with nothing pending, loaded with
    // cy_in on accept, and fed back from its own output outside SHIFT so it
    // holds the final carry through DONE.
    assign carry_load = start_accept & ~rst;
    assign carry_rst  = rst | ((state == IDLE) & ~start);
    assign carry_d    = (state == SHIFT) ? maj_bit : carry;

    dff u_carry (
        .clk   (clock),
        .rst   (carry_rst),
        .load  (carry_load),
        .cy_in (cy_in),
        .in    (carry_d),
        .out   (carry)
    );

    // Controller and datapath registers: capture on accept, shift in SHIFT.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            count <= '0;
            sum   <= '0;
        end else if (start_accept) begin
            state <= SHIFT;
            a_sr  <= a;
            b_sr  <= b;
            count <= '0;
            sum   <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign cout = carry;

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: expected {cout,sum} is pushed when a
// start is driven and compared when done pulses.
module tb_serial_add_unit;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cy_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int busy_run = 0;
    logic [W:0] exp_q[$];

    always #5 clock = ~clock;

    serial_add_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cy_in (cy_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: count busy cycles and compare each done against the scoreboard.
    always @(negedge clock) begin
        if (!rst) begin
            if (busy) busy_run++;
            if (done) begin
                check("busy_len", busy_run, W);
                if (exp_q.size() == 0) begin
                    check("unexp_done", done, 1'b0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("sum", sum, e[W-1:0]);
                    check("cout", cout, e[W]);
                end
            end
            if (!busy && !done) busy_run = 0;
            if (done || !busy) busy_run = busy ? busy_run : 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci);
        a = aa; b = bb; cy_in = ci; start = 1'b1;
        exp_q.push_back({1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ci});
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check("timeout", 1, 0);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci);
        drive_start(aa, bb, ci);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        wait_empty();
        tick();
    endtask

    initial begin
        int n;
        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;
        tick();

        // Basic additions and carry boundaries
        run_op(8'h35, 8'h4A, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 4; i++)
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // Start during SHIFT is ignored
        drive_start(8'h12, 8'h34, 1'b0);
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h00; b = 8'h00; cy_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ignored_start", busy, 1);
        wait_empty();
        tick();

        // Reset mid-operation discards the result
        drive_start(8'hAA, 8'h55, 1'b0);
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n++;
        end
        check("midrst_no_done", n, 0);

        // Back-to-back: start held in the DONE cycle
        drive_start(8'h35, 8'h4A, 1'b0);
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_reach_done", done, 1);
        check("b2b_prev_sum", sum, 8'h7F);
        drive_start(8'h01, 8'h01, 1'b0);
        tick();
        start = 1'b0;
        check("b2b_no_idle", busy, 1);
        wait_empty();
        tick();

        // Reset and start together: reset wins
        rst = 1'b1; a = 8'h77; b = 8'h11; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_sum", sum, 0);
        tick();
        check("rst_start_busy2", busy, 0);
        check("rst_start_sum2", sum, 0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
